// File: rtl/sign_extender.sv
// Sign-extends the IR immediate (IR_msb=0) or branch offset (IR_msb=1) to OUT_W bits,
// with a registered copy. Optional macro SE_BRANCH_WORD_EN word-scales branch offsets.
module sign_extender #(
    parameter int unsigned IMM_W = 11,
    parameter int unsigned BR_W  = 13,
    parameter int unsigned OUT_W = 16
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic [IMM_W-1:0] IR_immediate,
    input  logic [BR_W-1:0]  IR_branch,
    input  logic             IR_msb,
    output logic [OUT_W-1:0] SEOUT,
    output logic [OUT_W-1:0] SEOUT_q,
    output logic             SE_neg
);

    logic signed [IMM_W-1:0] imm_s;
    logic [OUT_W-1:0]        imm_ext;
    logic [OUT_W-1:0]        br_ext;

    assign imm_s   = IR_immediate;
    assign imm_ext = OUT_W'(imm_s);

`ifdef SE_BRANCH_WORD_EN
    // Append a zero LSB first so the word scaling keeps the sign of the offset.
    logic signed [BR_W:0] br_s;
    assign br_s   = {IR_branch, 1'b0};
    assign br_ext = OUT_W'(br_s);
`else
    logic signed [BR_W-1:0] br_s;
    assign br_s   = IR_branch;
    assign br_ext = OUT_W'(br_s);
`endif

    // A true mux: the unselected field never reaches SEOUT.
    always_comb begin
        SEOUT = imm_ext;
        if (IR_msb) begin
            SEOUT = br_ext;
        end
    end

    assign SE_neg = SEOUT[OUT_W-1];

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            SEOUT_q <= '0;
        end else begin
            SEOUT_q <= SEOUT;
        end
    end

endmodule

// File: tb/tb_sign_extender.sv
// Self-checking bench for sign_extender: directed boundary cases, register/reset timing,
// and randomized inputs against an arithmetic reference model.
module tb_sign_extender;

    logic        CLK;
    logic        Reset;
    logic [10:0] IR_immediate;
    logic [12:0] IR_branch;
    logic        IR_msb;
    logic [15:0] SEOUT;
    logic [15:0] SEOUT_q;
    logic        SE_neg;

    int n_total = 0;
    int n_bad   = 0;
    logic [15:0] exp_q;

    sign_extender #(
        .IMM_W(11),
        .BR_W (13),
        .OUT_W(16)
    ) dut (
        .CLK         (CLK),
        .Reset       (Reset),
        .IR_immediate(IR_immediate),
        .IR_branch   (IR_branch),
        .IR_msb      (IR_msb),
        .SEOUT       (SEOUT),
        .SEOUT_q     (SEOUT_q),
        .SE_neg      (SE_neg)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference value: interpret the selected field as a signed integer, then wrap to 16 bits.
    function automatic logic [15:0] ref_se(input logic msb, input logic [10:0] imm,
                                           input logic [12:0] br);
        int v;
        if (!msb) begin
            v = int'(imm);
            if (v >= 1024) v = v - 2048;
        end else begin
            v = int'(br);
            if (v >= 4096) v = v - 8192;
`ifdef SE_BRANCH_WORD_EN
            v = v * 2;
`endif
        end
        return 16'(v);
    endfunction

    // Expected register contents, tracked from the inputs seen at each edge.
    always @(posedge CLK or posedge Reset) begin
        if (Reset) exp_q = 16'h0000;
        else       exp_q = ref_se(IR_msb, IR_immediate, IR_branch);
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic msb, input logic [10:0] imm, input logic [12:0] br);
        @(negedge CLK);
        IR_msb       = msb;
        IR_immediate = imm;
        IR_branch    = br;
        #1;
    endtask

    task automatic check_comb(input string tag, input logic [15:0] exp);
        check(tag, SEOUT, exp);
        check({tag, "_neg"}, {15'd0, SE_neg}, {15'd0, exp[15]});
    endtask

    logic [10:0] imm_tab [5] = '{11'h7FC, 11'h1FC, 11'h000, 11'h7FF, 11'h3FF};
    logic [15:0] imm_exp [5] = '{16'hFFFC, 16'h01FC, 16'h0000, 16'hFFFF, 16'h03FF};
    logic [12:0] br_tab  [6] = '{13'h1FFC, 13'h01FC, 13'h0000, 13'h1FFF, 13'h0FFF, 13'h1000};
    logic [15:0] br_exp  [6] = '{16'hFFFC, 16'h01FC, 16'h0000, 16'hFFFF, 16'h0FFF, 16'hF000};

    initial begin
        Reset        = 1'b1;
        IR_msb       = 1'b0;
        IR_immediate = 11'h000;
        IR_branch    = 13'h0000;
        repeat (2) @(posedge CLK);
        #1;
        check("reset_q", SEOUT_q, 16'h0000);

        // Combinational path works while reset is held; register stays clear.
        drive(1'b0, 11'h400, 13'h0001);
        check_comb("comb_in_reset", 16'hFC00);
        @(posedge CLK); #1;
        check("q_held_in_reset", SEOUT_q, 16'h0000);
        @(negedge CLK);
        Reset = 1'b0;

        for (int i = 0; i < 5; i++) begin
            drive(1'b0, imm_tab[i], 13'h0001);
            check_comb($sformatf("imm_%0d", i), imm_exp[i]);
        end
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 11'h00C, br_tab[i]);
            check_comb($sformatf("br_%0d", i), br_exp[i]);
        end
        drive(1'b1, 11'h7AA, 13'h1FFF);
        check_comb("br_ignores_imm", 16'hFFFF);

        // Registered path: one-cycle latency, holds between edges.
        drive(1'b0, 11'h400, 13'h0000);
        check("q_before_edge", SEOUT_q, 16'hFFFF);
        @(posedge CLK); #1;
        check("q_after_edge", SEOUT_q, 16'hFC00);
        IR_immediate = 11'h123;
        #1;
        check("q_holds", SEOUT_q, 16'hFC00);
        check_comb("comb_follows", 16'h0123);
        @(posedge CLK); #1;
        check("q_next_edge", SEOUT_q, 16'h0123);

        // Asynchronous reset mid-cycle.
        drive(1'b0, 11'h7FF, 13'h0000);
        @(posedge CLK); #1;
        check("q_ffff", SEOUT_q, 16'hFFFF);
        #2;
        Reset = 1'b1;
        #1;
        check("async_clear", SEOUT_q, 16'h0000);
        check_comb("comb_during_reset", 16'hFFFF);
        @(posedge CLK); #1;
        check("q_zero_while_reset", SEOUT_q, 16'h0000);
        @(negedge CLK);
        Reset = 1'b0;
        #1;
        check("q_zero_after_release", SEOUT_q, 16'h0000);
        @(posedge CLK); #1;
        check("q_reload", SEOUT_q, 16'hFFFF);

        // Select toggle.
        drive(1'b0, 11'h001, 13'h1000);
        check_comb("toggle_0", 16'h0001);
        IR_msb = 1'b1; #1;
        check_comb("toggle_1", 16'hF000);
        IR_msb = 1'b0; #1;
        check_comb("toggle_2", 16'h0001);

        // Randomized inputs with occasional reset pulses.
        for (int i = 0; i < 300; i++) begin
            drive(1'($urandom), 11'($urandom), 13'($urandom));
            check_comb("rand_comb", ref_se(IR_msb, IR_immediate, IR_branch));
            if ($urandom_range(0, 19) == 0) begin
                Reset = 1'b1;
                #1;
                check("rand_reset", SEOUT_q, 16'h0000);
                Reset = 1'b0;
            end
            @(posedge CLK); #1;
            check("rand_q", SEOUT_q, exp_q);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/sign_extender.md
Name: sign_extender

Overview:
- Converts the instruction-register immediate field into a 16-bit two's-complement operand for the accumulator datapath.
- IR_msb selects the source field:
  - IR_msb=0: 11-bit ALU/load immediate.
  - IR_msb=1: 13-bit branch offset.
- Primary output SEOUT is combinational, so it is usable in the same cycle the IR settles.
- A registered copy, SEOUT_q, is provided for pipelined consumers.

Parameters:
- IMM_W, 11, width of the IR immediate field.
- BR_W, 13, width of the IR branch-offset field.
- OUT_W, 16, output width; must be ≥ BR_W+1.

Ports:
- CLK  input  1  system clock; rising-edge active.
- Reset  input  1  asynchronous, active-high reset. Clears registered outputs only.
- IR_immediate  input  IMM_W  immediate field, two's complement.
- IR_branch  input  BR_W  branch-offset field, two's complement.
- IR_msb  input  1  source select: 0 = immediate, 1 = branch.
- SEOUT  output  OUT_W  combinational sign-extended result.
- SEOUT_q  output  OUT_W  SEOUT registered on the CLK rising edge.
- SE_neg  output  1  combinational; equals SEOUT[OUT_W-1].

Behaviour:
- IR_msb=0: SEOUT = {(OUT_W-IMM_W){IR_immediate[IMM_W-1]}, IR_immediate}. IR_branch is ignored.
- IR_msb=1: SEOUT = {(OUT_W-BR_W){IR_branch[BR_W-1]}, IR_branch}. IR_immediate is ignored.
- SEOUT and SE_neg are purely combinational:
  - Zero-cycle latency; they follow any input change with no clock.
  - They are unaffected by Reset.
- The numeric value of the selected field is always preserved; overflow is impossible.
- Unselected-field bits must never leak into SEOUT.
- IR_msb of X/Z is not supported.
- SEOUT_q:
  - Loads SEOUT on every CLK rising edge; no enable.
  - One-cycle latency.
- Reset:
  - Asserting Reset immediately forces SEOUT_q to 0, asynchronously and independent of CLK.
  - SEOUT_q holds 0 while Reset is high.
  - The first load occurs on the first CLK rising edge after Reset deasserts.
- Reset asserted mid-operation:
  - SEOUT_q clears immediately.
  - SEOUT continues to track its inputs.
- Boundary values:
  - All-zeros field gives 0x0000.
  - All-ones field gives 0xFFFF.
  - Most-positive immediate (0x3FF) gives 0x03FF.
  - Most-negative immediate (0x400) gives 0xFC00.
  - Most-positive branch (0x0FFF) gives 0x0FFF.
  - Most-negative branch (0x1000) gives 0xF000.

Optional Feature:
- Macro: SE_BRANCH_WORD_EN.
- When defined:
  - In branch mode, the offset is word-scaled: SEOUT = sign-extend({IR_branch, 1'b0}) to OUT_W.
  - Example: IR_branch=0x1FFC gives 0xFFF8.
  - Immediate mode is unchanged.
  - SEOUT_q and SE_neg follow SEOUT.
- When undefined (default): branch mode is a plain sign extension with no shift, as specified under Behaviour.
- All Test Plan values below assume the macro is undefined.

Test Plan:
- Immediate, negative:
  - Stimulus: IR_msb=0, IR_immediate=11'b11111111100, IR_branch=13'h0001.
  - Response: SEOUT=16'hFFFC, SE_neg=1.
- Immediate, positive and boundary values:
  - IR_immediate=11'b00111111100 gives 16'h01FC.
  - 11'h000 gives 16'h0000.
  - 11'h7FF gives 16'hFFFF.
  - 11'h3FF gives 16'h03FF.
  - 11'h400 gives 16'hFC00.
- Branch select:
  - Stimulus: IR_msb=1, IR_immediate=11'b00000001100, then each IR_branch value in turn:
  - 13'b1111111111100 gives 16'hFFFC.
  - 13'b0000111111100 gives 16'h01FC.
  - 13'h0000 gives 16'h0000.
  - 13'h1FFF gives 16'hFFFF.
  - Changing IR_immediate while IR_msb=1 leaves SEOUT unchanged.
- Registered path:
  - Stimulus: apply IR_msb=0, IR_immediate=11'h400 and clock once.
  - Response: SEOUT_q=16'hFC00 after that edge, not before.
  - Then change IR_immediate: SEOUT_q holds 16'hFC00 until the next rising edge.
- Asynchronous reset:
  - Stimulus: with SEOUT_q=16'hFFFF, assert Reset between clock edges.
  - Response: SEOUT_q=0 immediately, while SEOUT remains 16'hFFFF.
  - Release Reset: the next edge reloads 16'hFFFF.
- Select toggle:
  - Stimulus: IR_immediate=11'h001, IR_branch=13'h1000; toggle IR_msb 0→1→0.
  - Response: SEOUT goes 16'h0001 → 16'hF000 → 16'h0001 combinationally.
